fifo_burst_framer: RTL and testbench

FIFO_BURST_FRAMER -- requirements
Module: fifo_burst_framer

---
 rtl/fifo_burst_framer.sv | 111 +++++++++++
 tb/tb_fifo_burst_framer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_framer.sv
// Purpose: frames words from a first-word-fall-through FIFO into bursts of up to BURST_LEN beats, closing on full, idle timeout or flush.
// Latency: a word popped at edge N reaches the output stage at edge N+1 once its successor is visible or the burst is being closed.
// Backpressure: out_ready low freezes the output beat; at most one further word is popped into the hold stage while stalled.
module fifo_burst_framer #(
    parameter int DW        = 32,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [DW-1:0] in_data,
    input  logic          in_empty,
    output logic          in_rd_en,
    input  logic          flush,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          burst_active
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
    localparam logic [IW-1:0] IDLE_HIT = IW'(TIMEOUT - 1);

    logic [DW-1:0] hold_data_q, hold_data_d;
    logic          hold_valid_q, hold_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;

    logic out_free;
    logic cnt_full;
    logic timeout_hit;
    logic move;
    logic close_burst;

    // Handshake decode: a hold word only advances when it is known whether it ends the burst.
    always_comb begin
        out_free    = !out_valid_q || out_ready;
        cnt_full    = (cnt_q == CNT_LAST);
        timeout_hit = (idle_cnt_q >= IDLE_HIT) && in_empty;
        move        = hold_valid_q && out_free &&
                      (!in_empty || cnt_full || timeout_hit || flush);
        // With no successor visible the beat can only be moving because the burst is being closed.
        close_burst = cnt_full || in_empty;
        in_rd_en    = nreset && !in_empty && (!hold_valid_q || move);
    end

    // Next-state for hold stage, output stage, beat counter and idle counter.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        cnt_d        = cnt_q;
        idle_cnt_d   = '0;

        if (in_rd_en) begin
            hold_data_d  = in_data;
            hold_valid_d = 1'b1;
        end else if (move) begin
            hold_valid_d = 1'b0;
        end

        if (move) begin
            out_data_d  = hold_data_q;
            out_valid_d = 1'b1;
            out_last_d  = close_burst;
            cnt_d       = close_burst ? '0 : cnt_q + 1'b1;
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end

        if (hold_valid_q && in_empty && !move) begin
            idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset; reset drops any open burst.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            cnt_q        <= '0;
            idle_cnt_q   <= '0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            cnt_q        <= cnt_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign burst_active = (cnt_q != '0);

endmodule

// File: tb/tb_fifo_burst_framer.sv
// Directed and random bench for fifo_burst_framer with a queue-based FIFO model and scoreboard.
// Expected beats are queued when words are pushed and popped when a beat is accepted.
// Last-beat flags are checked where the directed step fixes them, burst length everywhere.
module tb_fifo_burst_framer;

    localparam int DW = 32;
    localparam int BL = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          nreset;
    logic [DW-1:0] in_data;
    logic          in_empty;
    logic          in_rd_en;
    logic          flush;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          burst_active;

    always #5 clk = ~clk;

    fifo_burst_framer #(.DW(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .in_data      (in_data),
        .in_empty     (in_empty),
        .in_rd_en     (in_rd_en),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .burst_active (burst_active)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_d[$];
    int            exp_l[$];   // 0/1 = required out_last, 2 = not checked

    int            cyc = 0;
    int            pops = 0;
    int            empty_cyc = 0;
    int            last_beat_cyc = 0;
    int            first_beat_cyc = -1;
    int            run_len = 0;
    int            push_cyc = 0;
    int            pops_before = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    bit            pop_now = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        in_empty = (fifo_q.size() == 0);
        in_data  = in_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] d, input int l);
        fifo_q.push_back(d);
        exp_d.push_back(d);
        exp_l.push_back(l);
        drive();
    endtask

    // One clock: check outputs at the falling edge, then apply pops after the rising edge.
    task automatic step();
        logic [DW-1:0] d;
        int            l;
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_data", out_data, prev_data);
            chk("stall_last", DW'(out_last), DW'(prev_last));
        end
        if (out_valid === 1'b1 && out_ready) begin
            chk("beat_expected", DW'(exp_d.size() != 0), 1);
            if (exp_d.size() != 0) begin
                d = exp_d.pop_front();
                l = exp_l.pop_front();
                chk("beat_data", out_data, d);
                if (l != 2) chk("beat_last", DW'(out_last), DW'(l));
            end
            run_len++;
            chk("burst_len", DW'(run_len <= BL), 1);
            if (out_last) run_len = 0;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready && nreset;
        prev_data  = out_data;
        prev_last  = out_last;
        pop_now    = in_rd_en;
        @(posedge clk);
        cyc++;
        #1;
        if (pop_now && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pops++;
            if (fifo_q.size() == 0) empty_cyc = cyc;
        end
        drive();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && exp_d.size() != 0; i++) step();
        chk(tag, DW'(exp_d.size()), 0);
    endtask

    initial begin
        nreset    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive();

        // Reset holds everything idle even with a word waiting.
        push(32'hA5, 1);
        step();
        step();
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_out_last", DW'(out_last), 0);
        chk("rst_burst_active", DW'(burst_active), 0);
        chk("rst_in_rd_en", DW'(in_rd_en), 0);
        nreset = 1'b1;
        drain("init_drain");

        // Streaming: 8 preloaded words, bursts of 4, back to back.
        for (int i = 1; i <= 8; i++) push(DW'(i), (i == 4 || i == 8) ? 1 : 0);
        push_cyc       = cyc;
        first_beat_cyc = -1;
        drain("stream_drain");
        chk("stream_latency", DW'(first_beat_cyc - push_cyc), 2);
        chk("stream_back2back", DW'(last_beat_cyc - first_beat_cyc), 7);

        // Timeout: 3 words then empty; last beat closes TIMEOUT cycles after the FIFO empties.
        push(32'h31, 0);
        push(32'h32, 0);
        push(32'h33, 1);
        drain("timeout_drain");
        chk("timeout_latency", DW'(last_beat_cyc - empty_cyc), TO);

        // Backpressure mid-burst.
        for (int i = 1; i <= 8; i++) push(DW'(32'h40 + i), (i == 4 || i == 8) ? 1 : 0);
        step();
        step();
        step();
        out_ready   = 1'b0;
        pops_before = pops;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", DW'(out_valid), 1);
        end
        chk("stall_pops", DW'((pops - pops_before) <= 1), 1);
        out_ready = 1'b1;
        drain("bp_drain");

        // Flush with empty hold stage does nothing.
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_noop_valid", DW'(out_valid), 0);
        chk("flush_noop_active", DW'(burst_active), 0);

        // Flush closes a lone word three cycles after its pop.
        push(32'h55, 1);
        step();
        step();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("flush_drained", DW'(exp_d.size()), 0);
        chk("flush_latency", DW'(last_beat_cyc - empty_cyc), 4);
        chk("flush_burst_active", DW'(burst_active), 0);

        // Reset in the middle of a burst discards it; next burst starts from zero.
        for (int i = 1; i <= 6; i++) push(DW'(32'h60 + i), 2);
        step();
        step();
        step();
        chk("pre_rst_active", DW'(burst_active), 1);
        nreset = 1'b0;
        step();
        chk("mid_rst_out_valid", DW'(out_valid), 0);
        chk("mid_rst_burst_active", DW'(burst_active), 0);
        chk("mid_rst_in_rd_en", DW'(in_rd_en), 0);
        fifo_q.delete();
        exp_d.delete();
        exp_l.delete();
        run_len = 0;
        drive();
        step();
        nreset = 1'b1;
        for (int i = 1; i <= 4; i++) push(DW'(32'h70 + i), (i == 4) ? 1 : 0);
        drain("post_rst_drain");

        // Random stress on arrivals and backpressure.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) push(DW'($urandom), 2);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        out_ready = 1'b1;
        drain("stress_drain");
        chk("stress_run_len", DW'(run_len), 0);
        chk("stress_burst_active", DW'(burst_active), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
